// File: rtl/opb_regbank_pkg.sv
// opb_regbank_pkg: shared types and helpers for the OPB register bank
package opb_regbank_pkg;
  localparam int C_REGBANK_MAX = 63;
  typedef enum logic {IDLE, ACK} state_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old_data, input logic [31:0] new_data, input logic [3:0] be);
    for (int i = 0; i < 4; i++) be_merge[8*i+:8] = be[i] ? new_data[8*i+:8] : old_data[8*i+:8];
  endfunction
endpackage

// File: rtl/opb_regbank_decode.sv
// opb_regbank_decode: window range check, word offset and register map classification
module opb_regbank_decode
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h010B2300,
  parameter logic [31:0] C_HIGHADDR = 32'h010B23FF,
  parameter int          C_NUM_REGS = 4
) (
  input  logic [31:0] addr,
  output logic        in_range,
  output logic [29:0] off,
  output logic        is_ctrl,
  output logic        is_status
);
  logic [31:0] diff;
  logic        unused_lsb;
  assign diff       = addr - C_BASEADDR;
  assign in_range   = addr >= C_BASEADDR && addr <= C_HIGHADDR;
  assign off        = diff[31:2];
  assign is_ctrl    = off < 30'(C_NUM_REGS);
  assign is_status  = off == 30'(C_NUM_REGS);
  assign unused_lsb = ^diff[1:0];
endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: OPB slave bank of PPC-writable control registers plus one status word
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0]           C_BASEADDR   = 32'h010B2300,
  parameter logic [31:0]           C_HIGHADDR   = 32'h010B23FF,
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32,
  parameter int                    C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
  parameter string                 C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:31]                OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:31]                OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:31]                Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe,
  input  logic [31:0]                user_status_in
);
  localparam int IW = C_NUM_REGS > 1 ? $clog2(C_NUM_REGS) : 1;
  state_t                       state;
  logic                         in_range, is_ctrl, is_status, hit, commit, err;
  logic [29:0]                  off;
  logic                         rnw_q, ctrl_q, stat_q, pend;
  logic [IW-1:0]                idx_q;
  logic [3:0]                   be_q;
  logic [31:0]                  data_q, status_r, rdata;
  logic [C_NUM_REGS-1:0][31:0]  regs;
  logic                         unused_ok;
  opb_regbank_decode #(
    .C_BASEADDR(C_BASEADDR),
    .C_HIGHADDR(C_HIGHADDR),
    .C_NUM_REGS(C_NUM_REGS)
  ) u_decode (
    .addr     (OPB_ABus),
    .in_range (in_range),
    .off      (off),
    .is_ctrl  (is_ctrl),
    .is_status(is_status)
  );
  assign hit    = OPB_select && in_range;
  // an ACK cycle whose select has dropped is a master abort: nothing is acked or committed
  assign commit = state == ACK && OPB_select;
  assign err    = !ctrl_q && !(stat_q && rnw_q);
  always_comb rdata = (ctrl_q && !C_PULSE_MASK[idx_q]) ? regs[idx_q] : stat_q ? status_r : '0;
  assign Sl_xferAck     = commit;
  assign Sl_errAck      = commit && err;
  assign Sl_DBus        = (commit && rnw_q && !err) ? rdata : '0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_data_out  = regs;
  assign unused_ok      = ^{OPB_seqAddr, off[29:IW], 1'(C_OPB_AWIDTH), 1'(C_OPB_DWIDTH), C_FAMILY != "", C_NUM_REGS <= C_REGBANK_MAX};
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state          <= IDLE;
      rnw_q          <= 1'b0;
      ctrl_q         <= 1'b0;
      stat_q         <= 1'b0;
      idx_q          <= '0;
      be_q           <= '0;
      data_q         <= '0;
      status_r       <= '0;
      pend           <= 1'b0;
      regs           <= '0;
      user_wr_strobe <= '0;
    end else begin
      status_r       <= user_status_in;
      state          <= (state == IDLE && hit) ? ACK : IDLE;
      pend           <= commit && !rnw_q && ctrl_q;
      user_wr_strobe <= '0;
      if (state == IDLE && hit) begin
        rnw_q  <= OPB_RNW;
        ctrl_q <= is_ctrl;
        stat_q <= is_status;
        idx_q  <= off[IW-1:0];
        be_q   <= OPB_BE;
        data_q <= OPB_DBus;
      end
      // pending write lands one edge after the ack; pulse registers self-clear otherwise
      for (int i = 0; i < C_NUM_REGS; i++)
        if (pend && idx_q == IW'(i)) begin
          regs[i]           <= be_merge(regs[i], data_q, be_q);
          user_wr_strobe[i] <= 1'b1;
        end else if (C_PULSE_MASK[i]) regs[i] <= '0;
    end
  end
endmodule
